// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory loads/stores over a req/ack handshake,
// beq/bne branch resolution, write-back select and the MEM/WB boundary register.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no access outstanding; issues a memop or passes ALU/link data
// S_WAIT | request held on the bus until the single-cycle ack arrives
module mem_stage #(
   parameter int WAITCNT_W = 16
) (
   input  logic                 CLOCK,
   input  logic                 RESET_N,
   input  logic                 RegWriteEN_In,
   input  logic [1:0]           Mem2RegSEL_In,
   input  logic                 MemWriteEN_In,
   input  logic                 Beq_In,
   input  logic                 Bne_In,
   input  logic                 ZeroFlag_In,
   input  logic [31:0]          ALUResult_In,
   input  logic [31:0]          WriteData_In,
   input  logic [4:0]           RegWBAddr_In,
   input  logic [31:0]          PC_In,
   output logic                 DMemReq,
   output logic                 DMemWE,
   output logic [31:0]          DMemAddr,
   output logic [31:0]          DMemWData,
   input  logic [31:0]          DMemRData,
   input  logic                 DMemAck,
   output logic                 Stall_Out,
   output logic                 BranchTaken_Out,
   output logic [31:0]          BranchTarget_Out,
   output logic                 MisalignErr_Out,
   output logic                 RegWriteEN_Out,
   output logic [4:0]           RegWBAddr_Out,
   output logic [31:0]          WBData_Out,
   output logic [WAITCNT_W-1:0] WaitCount_Out
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [WAITCNT_W-1:0] WC_ONE = {{(WAITCNT_W-1){1'b0}}, 1'b1};

   state_t      state, state_nxt;
   logic        memop;
   logic        misalign;
   logic        issue;
   logic        mis_nxt;
   logic        wc_inc;
   logic        wb_en_nxt;
   logic [31:0] wb_data_nxt;
   logic [31:0] alu_or_link;

   assign memop       = MemWriteEN_In | (Mem2RegSEL_In == 2'b01);
   assign misalign    = memop & (ALUResult_In[1:0] != 2'b00);
   assign alu_or_link = (Mem2RegSEL_In == 2'b10) ? PC_In : ALUResult_In;

   // Branch redirect is purely combinational; a branch never coincides with a stall.
   assign BranchTaken_Out  = (Beq_In & ZeroFlag_In) | (Bne_In & ~ZeroFlag_In);
   assign BranchTarget_Out = PC_In;

   // Request follows the state register so an async reset drops it at once.
   assign DMemReq = (state == S_WAIT);

   always_comb begin
      state_nxt   = state;
      Stall_Out   = 1'b0;
      issue       = 1'b0;
      mis_nxt     = 1'b0;
      wc_inc      = 1'b0;
      wb_en_nxt   = 1'b0;
      wb_data_nxt = alu_or_link;
      case (state)
         S_IDLE: begin
            if (misalign) begin
               mis_nxt = 1'b1;
            end else if (memop) begin
               Stall_Out = 1'b1;
               issue     = 1'b1;
               state_nxt = S_WAIT;
            end else begin
               wb_en_nxt = RegWriteEN_In;
            end
         end
         S_WAIT: begin
            if (DMemAck) begin
               wb_en_nxt   = RegWriteEN_In;
               wb_data_nxt = DMemWE ? ALUResult_In : DMemRData;
               state_nxt   = S_IDLE;
            end else begin
               Stall_Out = 1'b1;
               wc_inc    = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         DMemWE    <= 1'b0;
         DMemAddr  <= 32'h0;
         DMemWData <= 32'h0;
      end else if (issue) begin
         DMemWE    <= MemWriteEN_In;
         DMemAddr  <= {ALUResult_In[31:2], 2'b00};
         DMemWData <= WriteData_In;
      end
   end

   // MEM/WB has no enable: stalls and misaligned accesses load bubbles.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         RegWriteEN_Out  <= 1'b0;
         RegWBAddr_Out   <= 5'd0;
         WBData_Out      <= 32'h0;
         MisalignErr_Out <= 1'b0;
      end else begin
         RegWriteEN_Out  <= wb_en_nxt;
         RegWBAddr_Out   <= RegWBAddr_In;
         WBData_Out      <= wb_data_nxt;
         MisalignErr_Out <= mis_nxt;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         WaitCount_Out <= '0;
      end else if (wc_inc && (WaitCount_Out != {WAITCNT_W{1'b1}})) begin
         WaitCount_Out <= WaitCount_Out + WC_ONE;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams checked against a transaction-level reference model.
module tb_mem_stage;

   localparam int WCW    = 4;
   localparam int WC_MAX = (1 << WCW) - 1;

   logic           CLOCK = 1'b0;
   logic           RESET_N;
   logic           RegWriteEN_In;
   logic [1:0]     Mem2RegSEL_In;
   logic           MemWriteEN_In;
   logic           Beq_In;
   logic           Bne_In;
   logic           ZeroFlag_In;
   logic [31:0]    ALUResult_In;
   logic [31:0]    WriteData_In;
   logic [4:0]     RegWBAddr_In;
   logic [31:0]    PC_In;
   logic           DMemReq;
   logic           DMemWE;
   logic [31:0]    DMemAddr;
   logic [31:0]    DMemWData;
   logic [31:0]    DMemRData;
   logic           DMemAck;
   logic           Stall_Out;
   logic           BranchTaken_Out;
   logic [31:0]    BranchTarget_Out;
   logic           MisalignErr_Out;
   logic           RegWriteEN_Out;
   logic [4:0]     RegWBAddr_Out;
   logic [31:0]    WBData_Out;
   logic [WCW-1:0] WaitCount_Out;

   int tests = 0;
   int fails = 0;
   int wc_model = 0;

   mem_stage #(.WAITCNT_W(WCW)) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N),
      .RegWriteEN_In(RegWriteEN_In), .Mem2RegSEL_In(Mem2RegSEL_In),
      .MemWriteEN_In(MemWriteEN_In), .Beq_In(Beq_In), .Bne_In(Bne_In),
      .ZeroFlag_In(ZeroFlag_In), .ALUResult_In(ALUResult_In),
      .WriteData_In(WriteData_In), .RegWBAddr_In(RegWBAddr_In), .PC_In(PC_In),
      .DMemReq(DMemReq), .DMemWE(DMemWE), .DMemAddr(DMemAddr),
      .DMemWData(DMemWData), .DMemRData(DMemRData), .DMemAck(DMemAck),
      .Stall_Out(Stall_Out), .BranchTaken_Out(BranchTaken_Out),
      .BranchTarget_Out(BranchTarget_Out), .MisalignErr_Out(MisalignErr_Out),
      .RegWriteEN_Out(RegWriteEN_Out), .RegWBAddr_Out(RegWBAddr_Out),
      .WBData_Out(WBData_Out), .WaitCount_Out(WaitCount_Out)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic drive_nop();
      RegWriteEN_In = 1'b0; Mem2RegSEL_In = 2'b00; MemWriteEN_In = 1'b0;
      Beq_In = 1'b0; Bne_In = 1'b0; ZeroFlag_In = 1'b0;
      ALUResult_In = 32'h0; WriteData_In = 32'h0; RegWBAddr_In = 5'd0; PC_In = 32'h0;
   endtask

   task automatic chk_wc();
      chk("wait_count", 32'(WaitCount_Out), 32'(wc_model));
   endtask

   // One instruction from issue to MEM/WB. kind: 0 = ALU/link/branch, 1 = load, 2 = store.
   // n = cycles spent waiting before the ack. Misalignment is decided by the address.
   task automatic do_op(input int kind, input logic regwe, input logic [1:0] sel,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wdata,
                        input logic [31:0] pc, input logic beq, input logic bne,
                        input logic zero, input int n, input logic [31:0] rdata,
                        input logic stray_ack);
      logic        is_mem;
      logic        bad;
      logic [31:0] exp_data;
      is_mem = (kind != 0);
      bad    = is_mem && (alu[1:0] != 2'b00);
      RegWriteEN_In = regwe;
      Mem2RegSEL_In = (kind == 1) ? 2'b01 : sel;
      MemWriteEN_In = (kind == 2);
      Beq_In = beq; Bne_In = bne; ZeroFlag_In = zero;
      ALUResult_In = alu; WriteData_In = wdata; RegWBAddr_In = rd; PC_In = pc;
      DMemAck = stray_ack;
      DMemRData = $urandom;
      #1;
      chk("branch_taken", 32'(BranchTaken_Out), 32'((beq && zero) || (bne && !zero)));
      chk("branch_target", BranchTarget_Out, pc);
      chk("issue_stall", 32'(Stall_Out), 32'(is_mem && !bad));
      chk("issue_req", 32'(DMemReq), 32'h0);
      tick();
      DMemAck = 1'b0;
      chk("misalign_pulse", 32'(MisalignErr_Out), 32'(bad));
      if (!is_mem) begin
         chk("alu_wb_en", 32'(RegWriteEN_Out), 32'(regwe));
         chk("alu_wb_addr", 32'(RegWBAddr_Out), 32'(rd));
         chk("alu_wb_data", WBData_Out, (sel == 2'b10) ? pc : alu);
         chk("alu_no_req", 32'(DMemReq), 32'h0);
         chk_wc();
         return;
      end
      chk("mem_issue_bubble", 32'(RegWriteEN_Out), 32'h0);
      if (bad) begin
         chk("misalign_no_req", 32'(DMemReq), 32'h0);
         chk_wc();
         return;
      end
      chk("req_up", 32'(DMemReq), 32'h1);
      chk("req_addr", DMemAddr, alu);
      chk("req_we", 32'(DMemWE), 32'(kind == 2));
      if (kind == 2) chk("req_wdata", DMemWData, wdata);
      for (int k = 0; k < n; k++) begin
         #1;
         chk("wait_stall", 32'(Stall_Out), 32'h1);
         tick();
         if (wc_model < WC_MAX) wc_model++;
         chk("wait_bubble", 32'(RegWriteEN_Out), 32'h0);
         chk("wait_req", 32'(DMemReq), 32'h1);
         chk("wait_addr_hold", DMemAddr, alu);
         chk("wait_we_hold", 32'(DMemWE), 32'(kind == 2));
         chk_wc();
      end
      DMemAck = 1'b1;
      DMemRData = rdata;
      #1;
      chk("ack_stall", 32'(Stall_Out), 32'h0);
      tick();
      DMemAck = 1'b0;
      exp_data = (kind == 1) ? rdata : alu;
      chk("ack_wb_en", 32'(RegWriteEN_Out), 32'(regwe));
      chk("ack_wb_addr", 32'(RegWBAddr_Out), 32'(rd));
      chk("ack_wb_data", WBData_Out, exp_data);
      chk("ack_req_down", 32'(DMemReq), 32'h0);
      chk("ack_misalign", 32'(MisalignErr_Out), 32'h0);
      chk_wc();
   endtask

   initial begin
      drive_nop();
      DMemAck = 1'b0;
      DMemRData = 32'h0;
      RESET_N = 1'b0;
      #2;
      chk("rst_req", 32'(DMemReq), 32'h0);
      chk("rst_we", 32'(DMemWE), 32'h0);
      chk("rst_addr", DMemAddr, 32'h0);
      chk("rst_wdata", DMemWData, 32'h0);
      chk("rst_wb_en", 32'(RegWriteEN_Out), 32'h0);
      chk("rst_wb_addr", 32'(RegWBAddr_Out), 32'h0);
      chk("rst_wb_data", WBData_Out, 32'h0);
      chk("rst_misalign", 32'(MisalignErr_Out), 32'h0);
      chk("rst_wc", 32'(WaitCount_Out), 32'h0);
      tick();
      RESET_N = 1'b1;
      tick();

      // ALU op, load with two wait cycles, single-cycle store, misaligned load, branches, link
      do_op(0, 1'b1, 2'b00, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      do_op(1, 1'b1, 2'b01, 5'd7, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 32'hDEADBEEF, 1'b0);
      do_op(2, 1'b0, 2'b00, 5'd0, 32'h44, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      do_op(1, 1'b1, 2'b01, 5'd9, 32'h42, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      do_op(0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h100, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
      do_op(0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h100, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b1);
      do_op(0, 1'b1, 2'b10, 5'd31, 32'h55, 32'h0, 32'h2000, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      // long wait drives the narrow counter into saturation
      do_op(1, 1'b1, 2'b01, 5'd3, 32'h80, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 20, 32'h600DF00D, 1'b0);

      // reset while a load is waiting; a late ack must be ignored
      do_op(0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0);
      RegWriteEN_In = 1'b1; Mem2RegSEL_In = 2'b01; ALUResult_In = 32'h100; RegWBAddr_In = 5'd4;
      tick();
      chk("midwait_req", 32'(DMemReq), 32'h1);
      #3;
      RESET_N = 1'b0;
      drive_nop();
      #1;
      wc_model = 0;
      chk("midwait_rst_req", 32'(DMemReq), 32'h0);
      chk("midwait_rst_stall", 32'(Stall_Out), 32'h0);
      chk("midwait_rst_addr", DMemAddr, 32'h0);
      chk("midwait_rst_wb_en", 32'(RegWriteEN_Out), 32'h0);
      chk_wc();
      tick();
      RESET_N = 1'b1;
      DMemAck = 1'b1;
      DMemRData = 32'hBAD0BAD0;
      tick();
      DMemAck = 1'b0;
      chk("late_ack_req", 32'(DMemReq), 32'h0);
      chk("late_ack_wb_en", 32'(RegWriteEN_Out), 32'h0);
      chk("late_ack_wb_data", WBData_Out, 32'h0);
      chk_wc();

      // randomized instruction stream, back-to-back
      for (int i = 0; i < 80; i++) begin
         int          kind;
         logic [1:0]  sel;
         logic [31:0] alu;
         kind = int'($urandom_range(0, 2));
         alu  = $urandom;
         if (kind != 0 && $urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
         sel  = 2'($urandom_range(0, 2));
         if (sel == 2'b01) sel = 2'b11;
         do_op(kind, 1'($urandom), sel, 5'($urandom), alu, $urandom, $urandom,
               (kind == 0) ? 1'($urandom) : 1'b0, (kind == 0) ? 1'($urandom) : 1'b0,
               1'($urandom), int'($urandom_range(0, 4)), $urandom, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
